// File: rtl/muldiv_sched.sv
// Shared multiply/divide scheduler for the dual-issue execute stage.
// One multi-cycle mul/div resource is time-shared by issue slot 1 and slot 2
// (slot 1 first). Multiplies complete in MUL_CYCLES, divides use a 32-step
// restoring divider followed by one sign-fix cycle. Both results are
// presented together for a single cycle in DONE and held until the next DONE.
module muldiv_sched #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        slot1_req,
    input  logic [1:0]  slot1_op,
    input  logic [31:0] slot1_src1,
    input  logic [31:0] slot1_src2,
    input  logic        slot2_req,
    input  logic [1:0]  slot2_op,
    input  logic [31:0] slot2_src1,
    input  logic [31:0] slot2_src2,
    output logic        stallreq_o,
    output logic        res_valid_o,
    output logic [63:0] res1_o,
    output logic [63:0] res2_o,
    output logic        busy_o
);

    // Divide occupancy is structural (32 iterations + fix), so it is not a parameter.
    localparam int         DIV_CYCLES = 33;
    localparam logic [5:0] MUL_LAST   = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST   = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r, next_s;
    logic        stall_s, accept_s, load_s, last_s;
    logic [1:0]  ld_op_s;
    logic [31:0] ld_a_s, ld_b_s;

    logic        req1_r, req2_r;
    logic [1:0]  s2_op_r;
    logic [31:0] s2_a_r, s2_b_r;
    logic [1:0]  run_op_r;
    logic [31:0] run_a_r, run_b_r;
    logic [5:0]  cnt_r;
    logic [31:0] rem_r, quo_r, dvs_r;
    logic [63:0] hold1_r, res1_r, res2_r;

    logic [32:0] partial_s;
    logic [33:0] diff_s;
    logic [63:0] ext_a_s, ext_b_s, prod_s, result_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    // Magnitude of an operand; only signed ops (op[0]==0) are negated.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        if (sgn && x[31]) begin
            mag = 32'd0 - x;
        end else begin
            mag = x;
        end
    endfunction

    // Last counter value for an op: occupancy minus one.
    function automatic logic [5:0] last_of(input logic [1:0] op);
        if (op[1]) begin
            last_of = DIV_LAST;
        end else begin
            last_of = MUL_LAST;
        end
    endfunction

    assign last_s = (cnt_r == 6'd0);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state, stall and run-entry operand selection.
    always_comb begin
        next_s   = state_r;
        stall_s  = 1'b0;
        accept_s = 1'b0;
        load_s   = 1'b0;
        ld_op_s  = slot1_op;
        ld_a_s   = slot1_src1;
        ld_b_s   = slot1_src2;
        case (state_r)
            IDLE: begin
                if (slot1_req || slot2_req) begin
                    stall_s  = 1'b1;
                    accept_s = 1'b1;
                    load_s   = 1'b1;
                    if (slot1_req) begin
                        next_s = RUN1;
                    end else begin
                        next_s  = RUN2;
                        ld_op_s = slot2_op;
                        ld_a_s  = slot2_src1;
                        ld_b_s  = slot2_src2;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            RUN1: begin
                stall_s = 1'b1;
                if (last_s && req2_r) begin
                    next_s  = RUN2;
                    load_s  = 1'b1;
                    ld_op_s = s2_op_r;
                    ld_a_s  = s2_a_r;
                    ld_b_s  = s2_b_r;
                end else if (last_s) begin
                    next_s = DONE;
                end else begin
                    next_s = RUN1;
                end
            end
            RUN2: begin
                stall_s = 1'b1;
                if (last_s) begin
                    next_s = DONE;
                end else begin
                    next_s = RUN2;
                end
            end
            DONE: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
        // A flush cancels whatever is in flight and refuses new work this cycle.
        if (flush) begin
            next_s   = IDLE;
            stall_s  = 1'b0;
            accept_s = 1'b0;
            load_s   = 1'b0;
        end else begin
            next_s = next_s;
        end
    end

    // Divider step and result formation for the operation currently running.
    always_comb begin
        partial_s = {rem_r, quo_r[31]};
        diff_s    = {1'b0, partial_s} - {2'b00, dvs_r};
        ext_a_s   = {{32{run_a_r[31] & ~run_op_r[0]}}, run_a_r};
        ext_b_s   = {{32{run_b_r[31] & ~run_op_r[0]}}, run_b_r};
        prod_s    = ext_a_s * ext_b_s;
        quo_fix_s = quo_r;
        rem_fix_s = rem_r;
        if (!run_op_r[0] && (run_a_r[31] ^ run_b_r[31])) begin
            quo_fix_s = 32'd0 - quo_r;
        end else begin
            quo_fix_s = quo_r;
        end
        if (!run_op_r[0] && run_a_r[31]) begin
            rem_fix_s = 32'd0 - rem_r;
        end else begin
            rem_fix_s = rem_r;
        end
        if (!run_op_r[1]) begin
            result_s = prod_s;
        end else if (run_b_r == 32'd0) begin
            result_s = {run_a_r, 32'hFFFF_FFFF};
        end else begin
            result_s = {rem_fix_s, quo_fix_s};
        end
    end

    // Operand latches, occupancy counter, divider registers and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req1_r   <= 1'b0;
            req2_r   <= 1'b0;
            s2_op_r  <= 2'b00;
            s2_a_r   <= 32'd0;
            s2_b_r   <= 32'd0;
            run_op_r <= 2'b00;
            run_a_r  <= 32'd0;
            run_b_r  <= 32'd0;
            cnt_r    <= 6'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            dvs_r    <= 32'd0;
            hold1_r  <= 64'd0;
            res1_r   <= 64'd0;
            res2_r   <= 64'd0;
        end else begin
            if (accept_s) begin
                req1_r  <= slot1_req;
                req2_r  <= slot2_req;
                s2_op_r <= slot2_op;
                s2_a_r  <= slot2_src1;
                s2_b_r  <= slot2_src2;
            end
            if (load_s) begin
                run_op_r <= ld_op_s;
                run_a_r  <= ld_a_s;
                run_b_r  <= ld_b_s;
                cnt_r    <= last_of(ld_op_s);
                rem_r    <= 32'd0;
                quo_r    <= mag(ld_a_s, ~ld_op_s[0]);
                dvs_r    <= mag(ld_b_s, ~ld_op_s[0]);
            end else if (busy_o && !last_s) begin
                cnt_r <= cnt_r - 6'd1;
                if (run_op_r[1]) begin
                    if (!diff_s[33]) begin
                        rem_r <= diff_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= partial_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                end
            end
            if (!flush && state_r == RUN1 && last_s) begin
                if (req2_r) begin
                    hold1_r <= result_s;
                end else begin
                    res1_r <= result_s;
                    res2_r <= 64'd0;
                end
            end
            if (!flush && state_r == RUN2 && last_s) begin
                res1_r <= req1_r ? hold1_r : 64'd0;
                res2_r <= result_s;
            end
        end
    end

    assign stallreq_o  = stall_s & resetn;
    assign busy_o      = (state_r == RUN1) || (state_r == RUN2);
    assign res_valid_o = (state_r == DONE) && !flush;
    assign res1_o      = res1_r;
    assign res2_o      = res2_r;

endmodule
